bow_tx_lane_ctrl: RTL and testbench



---
 rtl/bow_pkg.sv | 25 ++
 rtl/bow_sync_fifo.sv | 49 ++++
 rtl/bow_tx_lane_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bow_tx_lane_ctrl.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bow_pkg.sv
// Shared types and helpers for the Bunch-of-Wires transmit lane controller.
// Holds the lane FSM state encoding, the training pattern and sizing helpers.
package bow_pkg;

    typedef enum logic [1:0] {
        TRAIN,
        IDLE,
        SEND
    } state_t;

    function automatic int beats_of(input int word_w, input int lanes);
        return word_w / lanes;
    endfunction

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Training beat k on lane i: alternating 1010/0101 depending on k parity.
    function automatic logic train_bit(input int lane, input int k);
        return ((lane + k) % 2) != 0;
    endfunction

endpackage

// File: rtl/bow_sync_fifo.sv
// Single-clock FIFO with extended pointers; full/empty/level come from registered pointers.
// Pushes are ignored when full and pops when empty.
module bow_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/bow_tx_lane_ctrl.sv
// BoW transmit lane controller: APB write slave into a FIFO, then training/serialisation
// of words onto LANES data wires with parity (fec) and framing (aux) wires.
module bow_tx_lane_ctrl
    import bow_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int LANES     = 4,
    parameter int DEPTH     = 8,
    parameter int TRAIN_LEN = 16
) (
    input  logic                     txclk,
    input  logic                     preset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [WORD_W-1:0]        pwdata,
    output logic                     pready,
    output logic                     pslverr,
    input  logic                     rx_ready,
    input  logic                     train_req,
    output logic [LANES-1:0]         lane_data,
    output logic                     lane_fec,
    output logic                     lane_aux,
    output logic                     lane_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam int BEATS = beats_of(WORD_W, LANES);
    localparam int BW    = cnt_w(BEATS);
    localparam int KW    = cnt_w(TRAIN_LEN);

    state_t              r_state, w_state_nxt;
    logic [BW-1:0]       r_beat, w_beat_nxt;
    logic [KW-1:0]       r_k, w_k_nxt;
    logic                r_phase, w_phase_nxt;
    logic [WORD_W-1:0]   r_shift, w_shift_nxt;
    logic                r_train_pend, w_train_pend_nxt;
    logic [LANES-1:0]    r_lane_data, w_lane_data;
    logic                r_lane_fec, r_lane_aux, r_lane_valid;
    logic                w_lane_aux, w_lane_valid;

    logic                w_access;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [WORD_W-1:0]   w_fifo_dout;

    // APB handshake is combinational; full is the registered FIFO state.
    assign w_access = psel & penable & ~preset;
    assign pready   = w_access & (~pwrite | ~w_full);
    assign pslverr  = w_access & ~pwrite;
    assign w_push   = w_access & pwrite & ~w_full;

    bow_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (txclk),
        .i_rst   (preset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (pwdata),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_beat_nxt       = r_beat;
        w_k_nxt          = r_k;
        w_phase_nxt      = r_phase;
        w_shift_nxt      = r_shift;
        w_train_pend_nxt = r_train_pend | train_req;
        w_pop            = 1'b0;
        w_lane_data      = '0;
        w_lane_aux       = 1'b0;
        w_lane_valid     = 1'b0;

        case (r_state)
            TRAIN: begin
                for (int i = 0; i < LANES; i++) begin
                    w_lane_data[i] = train_bit(i, int'(r_phase));
                end
                w_lane_aux       = 1'b1;
                w_phase_nxt      = ~r_phase;
                w_train_pend_nxt = 1'b0;
                if (train_req) begin
                    w_k_nxt     = '0;
                    w_phase_nxt = 1'b0;
                end else if (r_k == KW'(TRAIN_LEN - 1)) begin
                    if (rx_ready) w_state_nxt = IDLE;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end

            IDLE: begin
                w_train_pend_nxt = 1'b0;
                if (train_req) begin
                    w_state_nxt = TRAIN;
                    w_k_nxt     = '0;
                    w_phase_nxt = 1'b0;
                end else if (~w_empty & rx_ready) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_beat_nxt  = '0;
                    w_state_nxt = SEND;
                end
            end

            SEND: begin
                w_lane_data  = r_shift[LANES-1:0];
                w_lane_aux   = (r_beat == '0);
                w_lane_valid = 1'b1;
                w_shift_nxt  = r_shift >> LANES;
                if (r_beat == BW'(BEATS - 1)) begin
                    // A pending training request wins over the next queued word.
                    if (w_train_pend_nxt) begin
                        w_state_nxt      = TRAIN;
                        w_k_nxt          = '0;
                        w_phase_nxt      = 1'b0;
                        w_train_pend_nxt = 1'b0;
                    end else if (~w_empty & rx_ready) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_beat_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_beat_nxt = r_beat + BW'(1);
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge txclk or posedge preset) begin
        if (preset) begin
            r_state      <= TRAIN;
            r_beat       <= '0;
            r_k          <= '0;
            r_phase      <= 1'b0;
            r_shift      <= '0;
            r_train_pend <= 1'b0;
            r_lane_data  <= '0;
            r_lane_fec   <= 1'b0;
            r_lane_aux   <= 1'b0;
            r_lane_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_k          <= w_k_nxt;
            r_phase      <= w_phase_nxt;
            r_shift      <= w_shift_nxt;
            r_train_pend <= w_train_pend_nxt;
            r_lane_data  <= w_lane_data;
            r_lane_fec   <= ^w_lane_data;
            r_lane_aux   <= w_lane_aux;
            r_lane_valid <= w_lane_valid;
        end
    end

    assign lane_data  = r_lane_data;
    assign lane_fec   = r_lane_fec;
    assign lane_aux   = r_lane_aux;
    assign lane_valid = r_lane_valid;
    assign busy       = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_bow_tx_lane_ctrl.sv
// Self-checking bench for bow_tx_lane_ctrl: lane activity is recorded every cycle and
// compared against a word/beat stream model derived from the transmit rules.
module tb_bow_tx_lane_ctrl;

    localparam int WORD_W    = 16;
    localparam int LANES     = 4;
    localparam int DEPTH     = 8;
    localparam int TRAIN_LEN = 16;
    localparam int BEATS     = WORD_W / LANES;

    logic              txclk = 1'b0;
    logic              preset = 1'b1;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [WORD_W-1:0] pwdata = '0;
    logic              rx_ready = 1'b0;
    logic              train_req = 1'b0;
    logic              pready;
    logic              pslverr;
    logic [LANES-1:0]  lane_data;
    logic              lane_fec;
    logic              lane_aux;
    logic              lane_valid;
    logic [3:0]        fifo_level;
    logic              busy;

    bow_tx_lane_ctrl #(
        .WORD_W    (WORD_W),
        .LANES     (LANES),
        .DEPTH     (DEPTH),
        .TRAIN_LEN (TRAIN_LEN)
    ) dut (
        .txclk      (txclk),
        .preset     (preset),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rx_ready   (rx_ready),
        .train_req  (train_req),
        .lane_data  (lane_data),
        .lane_fec   (lane_fec),
        .lane_aux   (lane_aux),
        .lane_valid (lane_valid),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 txclk = ~txclk;

    int cyc = 0;
    always @(posedge txclk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        logic       fec;
        logic       aux;
        logic       valid;
        logic       busy;
        logic [3:0] level;
    } sample_t;

    sample_t rec_q[$];
    int total = 0;
    int bad = 0;

    // Lane recorder: one sample per cycle, taken on the falling edge.
    always @(negedge txclk) begin
        sample_t s;
        s.cyc   = cyc;
        s.data  = lane_data;
        s.fec   = lane_fec;
        s.aux   = lane_aux;
        s.valid = lane_valid;
        s.busy  = busy;
        s.level = fifo_level;
        rec_q.push_back(s);
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] chunk(input logic [15:0] w, input int b);
        logic [15:0] t;
        t = w >> (LANES * b);
        return t[3:0];
    endfunction

    function automatic logic par(input logic [3:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Token layout: {valid, aux, fec, data}
    function automatic logic [6:0] pay_tok(input logic [15:0] w, input int b);
        logic [3:0] c;
        c = chunk(w, b);
        return {1'b1, (b == 0), par(c), c};
    endfunction

    function automatic logic [6:0] train_tok(input int k);
        logic [3:0] t;
        t = (k % 2 == 0) ? 4'hA : 4'h5;
        return {1'b0, 1'b1, par(t), t};
    endfunction

    function automatic logic [6:0] tok_of(input sample_t s);
        return {s.valid, s.aux, s.fec, s.data};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apb_write(input logic [15:0] d, output int acc);
        bit ok;
        @(posedge txclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = d;
        @(posedge txclk); #1;
        penable = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge txclk);
            if (pready) begin ok = 1'b1; break; end
        end
        acc = cyc + 1;
        @(posedge txclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL apb_write_wait got pready=0 want pready=1 within 64 cycles (data %h)", d);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int rel;
        int ntrain = 0;
        logic [6:0] exp;
        preset = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        #3;
        total++;
        if (pready !== 1'b0) begin bad++; $display("FAIL reset_pready got %b want 0", pready); end
        pwrite = 1'b0;
        #1;
        total++;
        if ({pready, pslverr} !== 2'b00) begin bad++; $display("FAIL reset_read_resp got %b want 00", {pready, pslverr}); end
        psel = 1'b0; penable = 1'b0;
        #1;
        total++;
        if ({lane_valid, lane_aux, lane_fec, lane_data} !== 7'h0) begin
            bad++; $display("FAIL reset_lanes got %h want 00", {lane_valid, lane_aux, lane_fec, lane_data});
        end
        total++;
        if (fifo_level !== 4'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_level_busy got level=%0d busy=%b want level=0 busy=1", fifo_level, busy);
        end
        repeat (3) @(posedge txclk); #1;
        rx_ready = 1'b1;
        rec_q.delete();
        rel = cyc;
        preset = 1'b0;
        repeat (20) @(posedge txclk); #1;
        foreach (rec_q[i]) begin
            int j;
            j = rec_q[i].cyc - rel;
            if (j >= 0 && j <= TRAIN_LEN + 2) begin
                exp = (j >= 1 && j <= TRAIN_LEN) ? train_tok(j - 1) : 7'h0;
                if (j >= 1 && j <= TRAIN_LEN) ntrain++;
                total++;
                if (tok_of(rec_q[i]) !== exp) begin
                    bad++; $display("FAIL reset_train_beat j=%0d got %h want %h", j, tok_of(rec_q[i]), exp);
                end
                if (j > TRAIN_LEN) begin
                    total++;
                    if (rec_q[i].busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy j=%0d got 1 want 0", j); end
                end
            end
        end
        total++;
        if (ntrain != TRAIN_LEN) begin bad++; $display("FAIL reset_train_count got %0d want %0d", ntrain, TRAIN_LEN); end
    endtask

    task automatic test_single_write();
        int acc;
        int nvalid = 0;
        logic [6:0] exp;
        rx_ready = 1'b1;
        rec_q.delete();
        apb_write(16'h1234, acc);
        repeat (8) @(posedge txclk); #1;
        foreach (rec_q[i]) begin
            int off;
            if (rec_q[i].cyc >= acc && rec_q[i].cyc <= acc + 7) begin
                off = rec_q[i].cyc - acc - 2;
                exp = (off >= 0 && off < BEATS) ? pay_tok(16'h1234, off) : 7'h0;
                if (rec_q[i].valid === 1'b1) nvalid++;
                total++;
                if (tok_of(rec_q[i]) !== exp) begin
                    bad++; $display("FAIL single_beat off=%0d got %h want %h", off, tok_of(rec_q[i]), exp);
                end
            end
        end
        total++;
        if (nvalid != BEATS) begin bad++; $display("FAIL single_valid_len got %0d want %0d", nvalid, BEATS); end
        total++;
        if (fifo_level !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_drain got level=%0d busy=%b want 0 0", fifo_level, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[$];
        sample_t vq[$];
        int acc;
        words.push_back(16'h1234);
        words.push_back(16'hBEEF);
        for (int i = 0; i < 4; i++) words.push_back(16'($urandom));
        rx_ready = 1'b1;
        rec_q.delete();
        foreach (words[i]) apb_write(words[i], acc);
        repeat (30) @(posedge txclk); #1;
        foreach (rec_q[i]) if (rec_q[i].valid === 1'b1) vq.push_back(rec_q[i]);
        total++;
        if (vq.size() != words.size() * BEATS) begin
            bad++; $display("FAIL b2b_beat_count got %0d want %0d", vq.size(), words.size() * BEATS);
        end
        for (int i = 0; i < vq.size() && i < words.size() * BEATS; i++) begin
            total++;
            if (tok_of(vq[i]) !== pay_tok(words[i / BEATS], i % BEATS)) begin
                bad++; $display("FAIL b2b_beat i=%0d got %h want %h", i, tok_of(vq[i]), pay_tok(words[i / BEATS], i % BEATS));
            end
            total++;
            if (vq[i].cyc != vq[0].cyc + i) begin
                bad++; $display("FAIL b2b_contiguous i=%0d got cyc %0d want %0d", i, vq[i].cyc, vq[0].cyc + i);
            end
        end
        total++;
        if (fifo_level !== 4'd0) begin bad++; $display("FAIL b2b_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_random_flow();
        logic [15:0] words[$];
        sample_t vq[$];
        bit done = 1'b0;
        for (int i = 0; i < 10; i++) words.push_back(16'($urandom));
        rec_q.delete();
        fork
            begin
                int acc;
                foreach (words[i]) begin
                    apb_write(words[i], acc);
                    repeat ($urandom_range(0, 3)) @(posedge txclk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge txclk); #1;
                    rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rx_ready = 1'b1;
        repeat (60) @(posedge txclk); #1;
        foreach (rec_q[i]) if (rec_q[i].valid === 1'b1) vq.push_back(rec_q[i]);
        total++;
        if (vq.size() != words.size() * BEATS) begin
            bad++; $display("FAIL rand_beat_count got %0d want %0d", vq.size(), words.size() * BEATS);
        end
        for (int i = 0; i < vq.size() && i < words.size() * BEATS; i++) begin
            total++;
            if (tok_of(vq[i]) !== pay_tok(words[i / BEATS], i % BEATS)) begin
                bad++; $display("FAIL rand_beat i=%0d got %h want %h", i, tok_of(vq[i]), pay_tok(words[i / BEATS], i % BEATS));
            end
            if (i % BEATS != 0) begin
                total++;
                if (vq[i].cyc != vq[i - 1].cyc + 1) begin
                    bad++; $display("FAIL rand_word_gap i=%0d got cyc %0d want %0d", i, vq[i].cyc, vq[i - 1].cyc + 1);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] words[$];
        sample_t vq[$];
        int acc;
        int waited = -1;
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) words.push_back(16'($urandom));
        rec_q.delete();
        for (int i = 0; i < DEPTH; i++) apb_write(words[i], acc);
        @(negedge txclk);
        total++;
        if (fifo_level !== 4'(DEPTH)) begin bad++; $display("FAIL full_level got %0d want %0d", fifo_level, DEPTH); end
        @(posedge txclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = words[DEPTH];
        @(posedge txclk); #1;
        penable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge txclk);
            total++;
            if (pready !== 1'b0 || fifo_level !== 4'(DEPTH)) begin
                bad++; $display("FAIL full_stall n=%0d got pready=%b level=%0d want 0 %0d", n, pready, fifo_level, DEPTH);
            end
        end
        @(posedge txclk); #1;
        rx_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge txclk);
            if (pready) begin waited = n; break; end
        end
        total++;
        if (waited != 1) begin bad++; $display("FAIL full_unblock got %0d cycles want 1", waited); end
        @(posedge txclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (50) @(posedge txclk); #1;
        foreach (rec_q[i]) if (rec_q[i].valid === 1'b1) vq.push_back(rec_q[i]);
        total++;
        if (vq.size() != words.size() * BEATS) begin
            bad++; $display("FAIL full_beat_count got %0d want %0d", vq.size(), words.size() * BEATS);
        end
        for (int i = 0; i < vq.size() && i < words.size() * BEATS; i++) begin
            total++;
            if (tok_of(vq[i]) !== pay_tok(words[i / BEATS], i % BEATS)) begin
                bad++; $display("FAIL full_beat i=%0d got %h want %h", i, tok_of(vq[i]), pay_tok(words[i / BEATS], i % BEATS));
            end
        end
    endtask

    task automatic test_apb_read();
        logic [15:0] w;
        int acc;
        int nvalid = 0;
        w = 16'($urandom);
        rx_ready = 1'b0;
        apb_write(w, acc);
        @(posedge txclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        @(negedge txclk);
        total++;
        if (pslverr !== 1'b0) begin bad++; $display("FAIL read_setup_err got 1 want 0"); end
        @(posedge txclk); #1;
        penable = 1'b1;
        @(negedge txclk);
        total++;
        if ({pready, pslverr} !== 2'b11) begin bad++; $display("FAIL read_resp got %b want 11", {pready, pslverr}); end
        total++;
        if (fifo_level !== 4'd1 || {lane_valid, lane_aux, lane_fec, lane_data} !== 7'h0) begin
            bad++; $display("FAIL read_no_change got level=%0d lanes=%h want 1 00", fifo_level, {lane_valid, lane_aux, lane_fec, lane_data});
        end
        @(posedge txclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge txclk);
        total++;
        if (pslverr !== 1'b0 || fifo_level !== 4'd1) begin
            bad++; $display("FAIL read_after got err=%b level=%0d want 0 1", pslverr, fifo_level);
        end
        rec_q.delete();
        @(posedge txclk); #1;
        rx_ready = 1'b1;
        repeat (8) @(posedge txclk); #1;
        foreach (rec_q[i]) begin
            if (rec_q[i].valid === 1'b1) begin
                total++;
                if (tok_of(rec_q[i]) !== pay_tok(w, nvalid % BEATS)) begin
                    bad++; $display("FAIL read_then_send b=%0d got %h want %h", nvalid, tok_of(rec_q[i]), pay_tok(w, nvalid % BEATS));
                end
                nvalid++;
            end
        end
        total++;
        if (nvalid != BEATS) begin bad++; $display("FAIL read_then_send_len got %0d want %0d", nvalid, BEATS); end
    endtask

    task automatic test_train_req();
        logic [6:0] exp_q[$];
        sample_t nz[$];
        int acc;
        int x;
        int rel;
        int j;
        logic [6:0] exp;
        // Training requested mid-word: word completes, training follows, queue resumes.
        rx_ready = 1'b0;
        apb_write(16'hAAAA, acc);
        apb_write(16'h5555, acc);
        rec_q.delete();
        @(posedge txclk); #1;
        rx_ready = 1'b1;
        x = cyc;
        repeat (3) @(posedge txclk); #1;
        train_req = 1'b1;
        @(posedge txclk); #1;
        train_req = 1'b0;
        repeat (30) @(posedge txclk); #1;
        for (int b = 0; b < BEATS; b++) exp_q.push_back(pay_tok(16'hAAAA, b));
        for (int k = 0; k < TRAIN_LEN; k++) exp_q.push_back(train_tok(k));
        for (int b = 0; b < BEATS; b++) exp_q.push_back(pay_tok(16'h5555, b));
        foreach (rec_q[i]) if (rec_q[i].cyc > x && tok_of(rec_q[i]) != 7'h0) nz.push_back(rec_q[i]);
        total++;
        if (nz.size() != exp_q.size()) begin bad++; $display("FAIL trq_token_count got %0d want %0d", nz.size(), exp_q.size()); end
        for (int i = 0; i < nz.size() && i < exp_q.size(); i++) begin
            total++;
            if (tok_of(nz[i]) !== exp_q[i]) begin
                bad++; $display("FAIL trq_token i=%0d got %h want %h", i, tok_of(nz[i]), exp_q[i]);
            end
        end
        if (nz.size() > BEATS) begin
            total++;
            if (nz[BEATS].cyc != nz[BEATS - 1].cyc + 1) begin
                bad++; $display("FAIL trq_train_start got cyc %0d want %0d", nz[BEATS].cyc, nz[BEATS - 1].cyc + 1);
            end
        end
        // Reset mid-word: everything clears at once and training restarts from beat 0.
        rx_ready = 1'b0;
        apb_write(16'h1234, acc);
        apb_write(16'hBEEF, acc);
        @(posedge txclk); #1;
        rx_ready = 1'b1;
        repeat (3) @(posedge txclk); #1;
        train_req = 1'b1;
        @(posedge txclk); #1;
        train_req = 1'b0;
        total++;
        if (lane_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_word_setup got valid=0 want 1"); end
        #2 preset = 1'b1;
        #1;
        total++;
        if ({lane_valid, lane_aux, lane_fec, lane_data} !== 7'h0 || fifo_level !== 4'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_async got lanes=%h level=%0d busy=%b want 00 0 1",
                            {lane_valid, lane_aux, lane_fec, lane_data}, fifo_level, busy);
        end
        @(posedge txclk); #1;
        rec_q.delete();
        rel = cyc;
        preset = 1'b0;
        repeat (24) @(posedge txclk); #1;
        foreach (rec_q[i]) begin
            j = rec_q[i].cyc - rel;
            if (j >= 1) begin
                exp = (j <= TRAIN_LEN) ? train_tok(j - 1) : 7'h0;
                total++;
                if (tok_of(rec_q[i]) !== exp) begin
                    bad++; $display("FAIL rst_restart j=%0d got %h want %h", j, tok_of(rec_q[i]), exp);
                end
            end
        end
    endtask

    task automatic test_train_hold();
        int t;
        int y;
        int first_zero = -1;
        logic [6:0] got;
        rx_ready = 1'b0;
        rec_q.delete();
        @(posedge txclk); #1;
        train_req = 1'b1;
        t = cyc;
        @(posedge txclk); #1;
        train_req = 1'b0;
        repeat (26) @(posedge txclk); #1;
        rx_ready = 1'b1;
        y = cyc;
        repeat (6) @(posedge txclk); #1;
        foreach (rec_q[i]) begin
            int c;
            c = rec_q[i].cyc;
            got = tok_of(rec_q[i]);
            if (c == t + 1) begin
                total++;
                if (got !== 7'h0) begin bad++; $display("FAIL hold_entry got %h want 00", got); end
            end else if (c >= t + 2 && c <= y) begin
                total++;
                if (got !== train_tok(c - t - 2)) begin
                    bad++; $display("FAIL hold_pattern k=%0d got %h want %h", c - t - 2, got, train_tok(c - t - 2));
                end
            end else if (c == y + 1) begin
                total++;
                if (got !== 7'h0 && got !== train_tok(c - t - 2)) begin
                    bad++; $display("FAIL hold_exit_beat got %h want 00 or %h", got, train_tok(c - t - 2));
                end
            end else if (c >= y + 2) begin
                if (first_zero < 0 && got == 7'h0) first_zero = c;
                total++;
                if (got !== 7'h0) begin bad++; $display("FAIL hold_exit got %h want 00 at cyc %0d", got, c); end
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_random_flow();
        test_fifo_full();
        test_apb_read();
        test_train_req();
        test_train_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
